// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the ram_responder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, RW direction constants, bus/counter widths.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  // Wide enough for the largest wait-state count (15).
  localparam int CNT_W  = 4;

endpackage

// File: rtl/ram_array.sv
// ram_array: DEPTH x 32 single-port storage, synchronous write and synchronous read.
// Latency: write lands and read data registers on the edge where en is high.
// Backpressure: none; one access per enabled cycle.
// Ports: clk/rst (rst clears only the read register, never the storage);
//        en/we/idx/wdat access strobe and bus; rdat registered read data, held between reads.
module ram_array
  import ram_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdat,
  output logic [DATA_W-1:0] rdat
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdat <= '0;
    end else if (en && !we) begin
      rdat <= mem[idx];
    end
  end

endmodule

// File: rtl/ram_responder.sv
// ram_responder: word-addressed RAM slave answering one access at a time after WAIT_STATES idle cycles.
// Latency: mem_ready pulses for one cycle WAIT_STATES+1 cycles after the request is captured in IDLE.
// Backpressure: none; mem_req is sampled only in IDLE, requests presented while busy are dropped.
// Ports: clk, Reset (synchronous, active-high); mem_req/RW/address/RAM_in request bus;
//        RAM_out registered read data; mem_ready completion pulse; mem_busy access in flight;
//        mem_err out-of-range pulse, present only when RAM_BOUNDS_CHECK_EN is defined.
module ram_responder
  import ram_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              mem_req,
  input  logic              RW,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] RAM_in,
  output logic [DATA_W-1:0] RAM_out,
  output logic              mem_ready,
  output logic              mem_busy
`ifdef RAM_BOUNDS_CHECK_EN
  ,
  output logic              mem_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              accept;
  logic              enter_resp;

  logic [AW-1:0]     idx_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdat_q;

  logic [AW-1:0]     acc_idx;
  logic              acc_rw;
  logic [DATA_W-1:0] acc_wdat;
  logic              acc_drop;

  logic              arr_en;
  logic [DATA_W-1:0] arr_rdat;

  assign accept = (state == IDLE) && mem_req;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          if (WAIT_STATES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Request bus snapshot; everything on the bus after this edge is ignored until IDLE.
  always_ff @(posedge clk) begin
    if (!Reset && accept) begin
      idx_q  <= address[AW-1:0];
      rw_q   <= RW;
      wdat_q <= RAM_in;
    end
  end

  // With no wait states the access completes on the capturing edge itself, so in IDLE the
  // live bus feeds the array; in WAIT the snapshot does.
  assign acc_idx  = (state == IDLE) ? address[AW-1:0] : idx_q;
  assign acc_rw   = (state == IDLE) ? RW              : rw_q;
  assign acc_wdat = (state == IDLE) ? RAM_in          : wdat_q;

`ifdef RAM_BOUNDS_CHECK_EN
  logic oob_q;
  logic acc_oob;
  logic rd_zero_q;
  logic err_q;

  always_ff @(posedge clk) begin
    if (!Reset && accept) begin
      oob_q <= (address >= ADDR_W'(DEPTH));
    end
  end

  assign acc_oob = (state == IDLE) ? (address >= ADDR_W'(DEPTH)) : oob_q;

  // An out-of-range read leaves the array register untouched and masks it to zero instead;
  // the mask sticks until the next completed read so RAM_out still holds between reads.
  always_ff @(posedge clk) begin
    if (Reset) begin
      rd_zero_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (enter_resp) begin
      err_q <= acc_oob;
      if (acc_rw == RW_READ) begin
        rd_zero_q <= acc_oob;
      end
    end
  end

  assign acc_drop = acc_oob;
  assign RAM_out  = rd_zero_q ? '0 : arr_rdat;
  assign mem_err  = (state == RESP) && err_q;
`else
  // Upper address bits wrap onto the array; they are intentionally not decoded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[ADDR_W-1:AW];

  assign acc_drop = 1'b0;
  assign RAM_out  = arr_rdat;
`endif

  // Reset on the edge that would enter RESP aborts the access, so a pending write is never committed.
  assign arr_en = enter_resp && !Reset && !acc_drop;

  ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk  (clk),
    .rst  (Reset),
    .en   (arr_en),
    .we   (acc_rw == RW_WRITE),
    .idx  (acc_idx),
    .wdat (acc_wdat),
    .rdat (arr_rdat)
  );

  assign mem_ready = (state == RESP);
  assign mem_busy  = (state != IDLE);

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: scoreboard bench for ram_responder with three instances (WAIT_STATES 1, 0, 3).
// Latency: expected responses are queued when a request is driven and popped on mem_ready.
// Backpressure: n/a.
module tb_ram_responder;
  import ram_pkg::*;

  typedef struct {
    int          dut;
    logic        is_rd;
    logic [31:0] dat;   // expected RAM_out at mem_ready (held value for writes)
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  rw  = '0;
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [31:0] rdat [3];
  logic [2:0]  rdy;
  logic [2:0]  busy;
  logic [2:0]  err;

  logic [31:0] model [3][256];
  logic [31:0] last_rd [3];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_responder #(
      .DEPTH       (256),
      .WAIT_STATES ((g == 0) ? 1 : (g == 1) ? 0 : 3)
    ) u_dut (
      .clk       (clk),
      .Reset     (rst),
      .mem_req   (req[g]),
      .RW        (rw[g]),
      .address   (addr[g]),
      .RAM_in    (wdat[g]),
      .RAM_out   (rdat[g]),
      .mem_ready (rdy[g]),
      .mem_busy  (busy[g])
`ifdef RAM_BOUNDS_CHECK_EN
      ,
      .mem_err   (err[g])
`endif
    );
`ifndef RAM_BOUNDS_CHECK_EN
    assign err[g] = 1'b0;
`endif
  end

  function automatic int ws(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  task automatic push_exp(input int d, input logic is_rd, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    logic oob;
    oob = 1'b0;
`ifdef RAM_BOUNDS_CHECK_EN
    oob = (a >= 32'd256);
`endif
    e.dut   = d;
    e.is_rd = is_rd;
    e.err   = oob;
    if (is_rd) begin
      e.dat = oob ? 32'h0 : model[d][a[7:0]];
      last_rd[d] = e.dat;
    end else begin
      e.dat = last_rd[d];
      if (!oob) model[d][a[7:0]] = wd;
    end
    sb.push_back(e);
  endtask

  // Drives one access from a negedge, scrambles the bus while it is in flight, and reports
  // what was observed. Ends on the negedge after mem_ready.
  task automatic access(input int d, input logic is_rd, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output int busy_n, output logic rdy_after,
                        output logic [31:0] rd_obs, output logic err_obs, output exp_t e);
    req[d]  = 1'b1;
    rw[d]   = is_rd;
    addr[d] = a;
    wdat[d] = wd;
    push_exp(d, is_rd, a, wd);
    @(posedge clk);
    lat = 0; busy_n = 0; rd_obs = '0; err_obs = 1'b0;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(negedge clk);
      req[d]  = 1'b0;
      rw[d]   = RW_WRITE;
      wdat[d] = 32'hBAD0_BAD0;
      if (busy[d]) busy_n++;
      if (rdy[d]) begin
        lat     = c;
        rd_obs  = rdat[d];
        err_obs = err[d];
      end
    end
    @(negedge clk);
    rdy_after = rdy[d];
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b1; rw[d] = RW_WRITE; addr[d] = 32'd7; wdat[d] = 32'h7777_7777;
      last_rd[d] = 32'h0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    for (int d = 0; d < 3; d++) begin
      checks++; if (rdat[d] !== 32'h0) begin errors++; $display("FAIL rst_ram_out[%0d]: got %h want 0", d, rdat[d]); end
      checks++; if (rdy[d] !== 1'b0) begin errors++; $display("FAIL rst_ready[%0d]: got %b want 0", d, rdy[d]); end
      checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL rst_busy[%0d]: got %b want 0", d, busy[d]); end
      checks++; if (err[d] !== 1'b0) begin errors++; $display("FAIL rst_err[%0d]: got %b want 0", d, err[d]); end
    end
    @(negedge clk);
    checks++; if (busy !== 3'b000) begin errors++; $display("FAIL rst_req_ignored: busy got %b want 000", busy); end
  endtask

  task automatic test_write_read();
    int lat, bn; logic ra, eo; logic [31:0] ro; exp_t e;
    access(0, RW_WRITE, 32'd5, 32'hDEAD_BEEF, lat, bn, ra, ro, eo, e);
    checks++; if (lat !== 2) begin errors++; $display("FAIL w1_wr_latency: got %0d want 2", lat); end
    checks++; if (bn !== 2) begin errors++; $display("FAIL w1_wr_busy_cycles: got %0d want 2", bn); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL w1_wr_ready_pulse: got %b want 0", ra); end
    checks++; if (ro !== e.dat) begin errors++; $display("FAIL w1_wr_ram_out_held: got %h want %h", ro, e.dat); end
    access(0, RW_READ, 32'd5, 32'h0, lat, bn, ra, ro, eo, e);
    checks++; if (lat !== 2) begin errors++; $display("FAIL w1_rd_latency: got %0d want 2", lat); end
    checks++; if (ro !== e.dat) begin errors++; $display("FAIL w1_rd_data: got %h want %h", ro, e.dat); end
    checks++; if (ro !== 32'hDEAD_BEEF) begin errors++; $display("FAIL w1_rd_deadbeef: got %h want deadbeef", ro); end
    repeat (2) @(negedge clk);
    checks++; if (rdat[0] !== last_rd[0]) begin errors++; $display("FAIL w1_rd_hold: got %h want %h", rdat[0], last_rd[0]); end
  endtask

  task automatic test_zero_wait();
    int lat, bn; logic ra, eo; logic [31:0] ro; exp_t e;
    access(1, RW_WRITE, 32'd5, 32'h1111_1111, lat, bn, ra, ro, eo, e);
    checks++; if (lat !== 1) begin errors++; $display("FAIL w0_wr_latency: got %0d want 1", lat); end
    access(1, RW_READ, 32'd5, 32'h0, lat, bn, ra, ro, eo, e);
    checks++; if (lat !== 1) begin errors++; $display("FAIL w0_rd_latency: got %0d want 1", lat); end
    checks++; if (bn !== 1) begin errors++; $display("FAIL w0_busy_cycles: got %0d want 1", bn); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL w0_ready_pulse: got %b want 0", ra); end
    checks++; if (ro !== e.dat) begin errors++; $display("FAIL w0_rd_data: got %h want %h", ro, e.dat); end
  endtask

  // mem_req held high on the WAIT_STATES=3 instance; bus is scrambled while each access is in WAIT.
  task automatic test_back_to_back();
    logic        op_rd [4];
    logic [31:0] op_a  [4];
    logic [31:0] op_d  [4];
    int k;
    exp_t e;
    op_rd = '{RW_WRITE, RW_WRITE, RW_READ, RW_READ};
    op_a  = '{32'd3, 32'd4, 32'd3, 32'd4};
    op_d  = '{32'hAAAA_0001, 32'hBBBB_0002, 32'h0, 32'h0};
    k = 0;
    req[2] = 1'b1; rw[2] = op_rd[0]; addr[2] = op_a[0]; wdat[2] = op_d[0];
    push_exp(2, op_rd[0], op_a[0], op_d[0]);
    for (int c = 1; c <= 40 && k < 4; c++) begin
      @(negedge clk);
      if (rdy[2]) begin
        e = sb.pop_front();
        checks++; if (c !== 4 + 5 * k) begin errors++; $display("FAIL b2b_ready_cycle[%0d]: got %0d want %0d", k, c, 4 + 5 * k); end
        checks++; if (rdat[2] !== e.dat) begin errors++; $display("FAIL b2b_ram_out[%0d]: got %h want %h", k, rdat[2], e.dat); end
        k++;
        if (k < 4) begin
          rw[2] = op_rd[k]; addr[2] = op_a[k]; wdat[2] = op_d[k];
          push_exp(2, op_rd[k], op_a[k], op_d[k]);
        end else begin
          req[2] = 1'b0;
        end
      end else if (busy[2]) begin
        rw[2] = RW_WRITE; addr[2] = 32'd3; wdat[2] = 32'hBAD0_BAD0;
      end
    end
    checks++; if (k !== 4) begin errors++; $display("FAIL b2b_completions: got %0d want 4", k); end
    req[2] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat, bn; logic ra, eo, saw; logic [31:0] ro; exp_t e;
    access(0, RW_WRITE, 32'd9, 32'h0000_0999, lat, bn, ra, ro, eo, e);
    req[0] = 1'b1; rw[0] = RW_WRITE; addr[0] = 32'd9; wdat[0] = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL abort_in_wait: busy got %b want 1", busy[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy[0]); end
    saw = rdy[0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      saw = saw | rdy[0];
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL abort_no_ready: got %b want 0", saw); end
    for (int d = 0; d < 3; d++) last_rd[d] = 32'h0;
    access(0, RW_READ, 32'd9, 32'h0, lat, bn, ra, ro, eo, e);
    checks++; if (ro !== e.dat) begin errors++; $display("FAIL abort_prior_value: got %h want %h", ro, e.dat); end
  endtask

  task automatic test_range();
    int lat, bn; logic ra, eo; logic [31:0] ro; exp_t e;
    access(0, RW_WRITE, 32'd5, 32'h0000_0055, lat, bn, ra, ro, eo, e);
    access(0, RW_WRITE, 32'h105, 32'hA5A5_A5A5, lat, bn, ra, ro, eo, e);
    checks++; if (lat !== 2) begin errors++; $display("FAIL range_wr_latency: got %0d want 2", lat); end
    checks++; if (eo !== e.err) begin errors++; $display("FAIL range_wr_err: got %b want %b", eo, e.err); end
    access(0, RW_READ, 32'd5, 32'h0, lat, bn, ra, ro, eo, e);
    checks++; if (ro !== e.dat) begin errors++; $display("FAIL range_rd5_data: got %h want %h", ro, e.dat); end
    checks++; if (eo !== 1'b0) begin errors++; $display("FAIL range_rd5_err: got %b want 0", eo); end
    access(0, RW_READ, 32'h105, 32'h0, lat, bn, ra, ro, eo, e);
    checks++; if (ro !== e.dat) begin errors++; $display("FAIL range_rd105_data: got %h want %h", ro, e.dat); end
    checks++; if (eo !== e.err) begin errors++; $display("FAIL range_rd105_err: got %b want %b", eo, e.err); end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      addr[d] = '0; wdat[d] = '0; last_rd[d] = '0;
    end
    test_reset();
    test_write_read();
    test_zero_wait();
    test_back_to_back();
    test_reset_abort();
    test_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, data RAM size in 32-bit words (power of two, 2..65536).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles inserted before each response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_req  input  1  access request, sampled only in IDLE.
REQ-006 SHALL have port RW  input  1  1 = read (LDR/ADR), 0 = write (STR).
REQ-007 SHALL have port address  input  32  word address from the memory-control address bus.
REQ-008 SHALL have port RAM_in  input  32  write data.
REQ-009 SHALL have port RAM_out  output  32  read data, registered, held between reads.
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port mem_busy  output  1  high while a captured access is in progress.
REQ-012 SHALL have port mem_err  output  1  out-of-range pulse; present only when RAM_BOUNDS_CHECK_EN is defined.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; one access in flight at most.
REQ-014 In IDLE with mem_req=1 SHALL capture address, RW, RAM_in at that edge; next state WAIT if WAIT_STATES>0, else RESP.
REQ-015 WAIT SHALL last exactly WAIT_STATES cycles (down-counter loaded with WAIT_STATES-1), then go to RESP.
REQ-016 Latency: mem_ready SHALL be high exactly WAIT_STATES+1 cycles after the capturing edge, for one cycle, in RESP.
REQ-017 RESP SHALL return to IDLE unconditionally; a new request is accepted the cycle after mem_ready at the earliest.
REQ-018 mem_req and bus changes during WAIT/RESP SHALL be ignored (no queuing, captured values used).
REQ-019 mem_busy SHALL be high in WAIT and RESP, low in IDLE.
REQ-020 Write: array word SHALL be updated on the edge entering RESP with captured RAM_in; RAM_out unchanged.
REQ-021 Read: RAM_out SHALL load the addressed word on the edge entering RESP and hold until the next completed read.
REQ-022 Index SHALL be address[clog2(DEPTH)-1:0]; upper bits ignored (wrap-around) unless REQ-027 applies.
REQ-023 Read-after-write to same address on back-to-back accesses SHALL return the newly written data.

Reset
REQ-024 Reset=1 SHALL force IDLE, counter 0, RAM_out=0, mem_ready=0, mem_busy=0, mem_err=0 at the next edge, overriding all other activity.
REQ-025 Reset during WAIT SHALL abort the access; a captured write SHALL NOT be committed; array contents are not cleared by reset.
REQ-026 mem_req asserted in the same cycle as Reset SHALL be ignored.

Configuration
REQ-027 With RAM_BOUNDS_CHECK_EN defined: address >= DEPTH SHALL drop writes, load RAM_out=0 on reads, and pulse mem_err with mem_ready; mem_ready timing unchanged.
REQ-028 Without RAM_BOUNDS_CHECK_EN: no mem_err port; out-of-range addresses wrap per REQ-022.

Structure
REQ-029 Package ram_pkg SHALL hold the state encoding (IDLE, WAIT, RESP) and constants RW_READ=1, RW_WRITE=0.
REQ-030 Sub-module ram_array SHALL hold storage: single-port, synchronous write, synchronous read, DEPTH x 32.

Verification
REQ-031 WAIT_STATES=1: write 0xDEADBEEF to addr 5, then read addr 5 -> mem_ready 2 cycles after each capture; RAM_out=0xDEADBEEF.
REQ-032 WAIT_STATES=0: read addr 5 -> mem_ready 1 cycle after capture; mem_busy high exactly 1 cycle.
REQ-033 Hold mem_req=1 continuously with WAIT_STATES=3 -> accesses captured every 5 cycles; bus changes mid-access have no effect.
REQ-034 Reset asserted during WAIT of write 0x12345678 to addr 9 -> no mem_ready; later read of addr 9 returns prior value.
REQ-035 DEPTH=256, write 0xA5A5A5A5 to addr 0x105 -> with RAM_BOUNDS_CHECK_EN: mem_err pulse, addr 5 unchanged; without: addr 5 reads 0xA5A5A5A5.
REQ-036 After reset, before any access -> RAM_out=0, mem_ready=0, mem_busy=0.
